ifetch_prefetch_buffer: RTL and testbench
=========================================

Name: ifetch_prefetch_buffer

Overview:
Instruction prefetch queue between a variable-latency instruction memory (req/ack) and the pipelined datapath fetch stage. It fetches sequential words ahead of pcF and serves instrF together with a valid flag. The datapath stalls F/D while instrvalidF is low. Any pcF that does not match the queue head (branch, jump, jr, jal) flushes the queue and restarts fetching at pcF.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk edge)
pcF  in  32  fetch address from datapath PC register
fetchen  in  1  datapath consumes the head this cycle (~stallF)
instrF  out  32  instruction for pcF; 32'h0 (nop) when not valid
instrvalidF  out  1  instrF is the word at pcF
imem_req  out  1  memory request, registered
imem_addr  out  32  request word address, registered, bits[1:0]=0
imem_ack  in  1  transfer completes this cycle; imem_rdata valid
imem_rdata  in  32  read data

Behaviour:
- Storage: DEPTH entries {addr[31:2], instr}, circular head/tail pointers plus a count 0..DEPTH. Registers: nextaddr, reqaddr, 2-bit state.
- Reset (reset==0 at an edge): count=0, pointers=0, state=IDLE, nextaddr=0, reqaddr=0, imem_req=0, imem_addr=0. Combinational outputs follow: instrvalidF=0, instrF=0. Reset overrides everything, including a request in flight. The memory side must tolerate the dropped request.
- expaddr (combinational):
  - count>0: head.addr
  - count==0, state BUSY: reqaddr
  - otherwise: nextaddr
- miss = (pcF[31:2] != expaddr).
- hit = (count>0 && !miss). instrvalidF = hit. instrF = hit ? head.instr : 0.
- pop = hit && fetchen. push = ack accepted in BUSY (below). Simultaneous push and pop leave count unchanged. Full/empty never overflow or underflow because issue is gated by room.
- room = (count - pop + push) < DEPTH.
- Flush on miss, at the next edge:
  - count, head and tail reset to 0; nextaddr=pcF.
  - BUSY with no ack goes to DISCARD.
  - BUSY with ack: the data is dropped.
- States:
  - IDLE: imem_req=0. At the edge, if room: state=BUSY, reqaddr = miss ? pcF : nextaddr, imem_req=1.
  - BUSY: imem_req=1, imem_addr=reqaddr, held stable until ack.
    - On ack without miss: push {reqaddr, imem_rdata}, nextaddr=reqaddr+4. If room after the push, stay BUSY with reqaddr+4 (back-to-back, 1 word/cycle). Otherwise go to IDLE, req=0.
    - On miss: see Flush.
  - DISCARD: req stays high until ack; the data is dropped.
    - On ack: reissue at nextaddr (stay BUSY-equivalent, go to BUSY with reqaddr=nextaddr) if room, else IDLE.
    - A further miss here only updates nextaddr=pcF.
- The handshake is never abandoned once imem_req=1, except by reset.
- Latency:
  - miss at cycle t gives req(pcF) at t+1.
  - with 0-wait ack at t+1, instrvalidF=1 at t+2.
  - steady-state sequential throughput is 1 instruction/cycle.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- pcF bits[1:0] are ignored in all comparisons.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with ack=1 -> imem_req=0, instrvalidF=0, instrF=0. Release with pcF=0 -> req addr 0x0 next cycle; instrvalidF=1 one cycle later.
2. Stream: ack tied 1, fetchen=1, pcF+=4 each valid cycle, imem returns addr^0xA5A50000 -> instrF valid every cycle for 0x0..0x3C with matching data, no bubbles after the first.
3. Fill: fetchen=0, pcF=0, ack=1 -> exactly 4 requests (0x0, 0x4, 0x8, 0xC), then req=0. Set fetchen=1 -> one pop per cycle and req resumes at 0x10.
4. Redirect with data queued: queue holds 0x10..0x1C, pcF changes to 0x100 -> instrvalidF=0 that cycle. Next req addr=0x100; first valid instrF is the word at 0x100; old entries are never delivered.
5. Redirect mid-request: req to 0x8 with ack delayed 3 cycles, pcF changes to 0x200 in the first wait cycle -> req/addr 0x8 held until ack, data discarded, next req addr=0x200.
6. Reset mid-operation: reset=0 while BUSY and count=3 -> next cycle req=0, count=0, nextaddr=0. After release, fetching restarts at pcF=0.

Source files
------------

// File: rtl/ifetch_prefetch_buffer_if.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch_buffer_if
//
// Bundles the two sides of the instruction prefetch buffer:
//   fetch side : pcF (fetch address), fetchen (head consumed this cycle),
//                instrF / instrvalidF (instruction served for pcF)
//   memory side: imem_req / imem_addr (registered request),
//                imem_ack / imem_rdata (transfer completion and read data)
//
// Modports:
//   master : the prefetch buffer itself (drives instrF, instrvalidF,
//            imem_req, imem_addr)
//   slave  : the surrounding datapath plus instruction memory
// -----------------------------------------------------------------------------
interface ifetch_prefetch_buffer_if;
  logic [31:0] pcF;
  logic        fetchen;
  logic [31:0] instrF;
  logic        instrvalidF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    input  pcF,
    input  fetchen,
    input  imem_ack,
    input  imem_rdata,
    output instrF,
    output instrvalidF,
    output imem_req,
    output imem_addr
  );

  modport slave (
    output pcF,
    output fetchen,
    output imem_ack,
    output imem_rdata,
    input  instrF,
    input  instrvalidF,
    input  imem_req,
    input  imem_addr
  );
endinterface

// File: rtl/ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch_buffer
//
// Instruction prefetch queue between a variable-latency instruction memory
// (req/ack handshake) and the pipelined fetch stage. Sequential words ahead
// of pcF are fetched into a DEPTH-entry circular queue; the head is served
// combinationally as instrF/instrvalidF when its address matches pcF. Any pcF
// that does not match the expected head address flushes the queue and
// restarts fetching at pcF. A request already on the bus is always carried
// to its ack (the returned word is then dropped); only reset abandons it.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset
//   bus    : ifetch_prefetch_buffer_if.master
//            pcF, fetchen             fetch-side inputs
//            instrF, instrvalidF      combinational fetch-side outputs
//            imem_req, imem_addr      registered memory request
//            imem_ack, imem_rdata     memory completion and data
//
// Parameters:
//   DEPTH  : number of queue entries (power of two, >= 2)
// -----------------------------------------------------------------------------
module ifetch_prefetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  ifetch_prefetch_buffer_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C   = DEPTH[CW:0];
  localparam logic [PW-1:0] PTR_ONE_C = PW'(1'b1);

  // IDLE: no request on the bus. BUSY: request whose data will be queued.
  // DISCARD: request still on the bus whose data is no longer wanted.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_DISCARD = 2'b10
  } state_e;

  // Queue storage: word address and instruction per entry
  logic [29:0]   ent_addr_q  [DEPTH];
  logic [31:0]   ent_instr_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   nextaddr_q, nextaddr_d;
  logic [31:0]   reqaddr_q, reqaddr_d;
  state_e        state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic [31:0]   imem_addr_q, imem_addr_d;

  logic [29:0]   exp_addr_s;
  logic          miss_s;
  logic          hit_s;
  logic          pop_s;
  logic          push_s;
  logic [CW:0]   cnt_next_s;
  logic          room_s;
  logic [31:0]   pcf_word_s;
  logic [31:0]   instr_s;
  logic [1:0]    unused_pc_bits_s;

  // The byte offset of pcF never takes part in any comparison
  assign unused_pc_bits_s = bus.pcF[1:0];
  assign pcf_word_s       = {bus.pcF[31:2], 2'b00};

  // Expected head address, miss/hit detection and occupancy after this cycle.
  // With an empty queue the word that will arrive next is the one in flight
  // (BUSY) or, when nothing useful is in flight, the next sequential word.
  always_comb begin
    exp_addr_s = nextaddr_q[31:2];
    if (count_q != {CW{1'b0}}) begin
      exp_addr_s = ent_addr_q[head_q];
    end else if (state_q == ST_BUSY) begin
      exp_addr_s = reqaddr_q[31:2];
    end else begin
      exp_addr_s = nextaddr_q[31:2];
    end
    miss_s     = (bus.pcF[31:2] != exp_addr_s);
    hit_s      = (count_q != {CW{1'b0}}) && !miss_s;
    pop_s      = hit_s && bus.fetchen;
    push_s     = (state_q == ST_BUSY) && bus.imem_ack && !miss_s;
    cnt_next_s = {1'b0, count_q} - {{CW{1'b0}}, pop_s} + {{CW{1'b0}}, push_s};
    room_s     = (cnt_next_s < DEPTH_C);
  end

  // Head instruction is presented only while it is the word at pcF
  always_comb begin
    instr_s = 32'h0000_0000;
    if (hit_s) begin
      instr_s = ent_instr_q[head_q];
    end else begin
      instr_s = 32'h0000_0000;
    end
  end

  assign bus.instrF      = instr_s;
  assign bus.instrvalidF = hit_s;
  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;

  // Next-state: queue pointers/occupancy and request FSM
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    nextaddr_d = nextaddr_q;
    reqaddr_d  = reqaddr_q;
    imem_req_d = imem_req_q;

    // Queue bookkeeping: a miss empties the queue and retargets fetching
    if (miss_s) begin
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      nextaddr_d = pcf_word_s;
    end else begin
      count_d = cnt_next_s[CW-1:0];
      if (pop_s) begin
        head_d = head_q + PTR_ONE_C;
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d     = tail_q + PTR_ONE_C;
        nextaddr_d = reqaddr_q + 32'd4;
      end else begin
        tail_d     = tail_q;
        nextaddr_d = nextaddr_q;
      end
    end

    // Request FSM. After a miss the queue is empty, so there is always room.
    case (state_q)
      ST_IDLE: begin
        if (miss_s || room_s) begin
          state_d    = ST_BUSY;
          reqaddr_d  = miss_s ? pcf_word_s : nextaddr_q;
          imem_req_d = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          imem_req_d = 1'b0;
        end
      end
      ST_BUSY: begin
        imem_req_d = 1'b1;
        if (bus.imem_ack) begin
          if (miss_s) begin
            // Completing word is dropped; restart straight away at pcF
            state_d   = ST_BUSY;
            reqaddr_d = pcf_word_s;
          end else if (room_s) begin
            // Back-to-back sequential request, one word per cycle
            state_d   = ST_BUSY;
            reqaddr_d = reqaddr_q + 32'd4;
          end else begin
            state_d    = ST_IDLE;
            imem_req_d = 1'b0;
          end
        end else begin
          // Address stays on the bus until ack; a miss only marks it stale
          if (miss_s) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_DISCARD: begin
        imem_req_d = 1'b1;
        if (bus.imem_ack) begin
          if (miss_s || room_s) begin
            state_d   = ST_BUSY;
            reqaddr_d = nextaddr_d;
          end else begin
            state_d    = ST_IDLE;
            imem_req_d = 1'b0;
          end
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a quiet bus
        state_d    = ST_IDLE;
        imem_req_d = 1'b0;
      end
    endcase

    imem_addr_d = reqaddr_d;
  end

  // Control registers; reset also drops any request on the bus
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      nextaddr_q  <= 32'h0000_0000;
      reqaddr_q   <= 32'h0000_0000;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      nextaddr_q  <= nextaddr_d;
      reqaddr_q   <= reqaddr_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // Entry storage: the completing word is written at the tail on push
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i]  <= 30'h0;
        ent_instr_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      ent_addr_q[tail_q]  <= reqaddr_q[31:2];
      ent_instr_q[tail_q] <= bus.imem_rdata;
    end else begin
      ent_addr_q[tail_q]  <= ent_addr_q[tail_q];
      ent_instr_q[tail_q] <= ent_instr_q[tail_q];
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_ifetch_prefetch_buffer
//
// Self-checking bench. A transaction-level model (a queue of fetched word
// addresses plus an "outstanding request" record) predicts instrvalidF,
// instrF, imem_req and imem_addr every cycle. Directed scenarios add literal
// expectations; a randomized phase exercises redirects, stalls, slow acks,
// address wrap-around and mid-operation resets.
// The memory returns addr ^ 32'hA5A50000, and garbage whenever ack is low.
// -----------------------------------------------------------------------------
module tb_ifetch_prefetch_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_prefetch_buffer_if bus ();

  ifetch_prefetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model state
  logic [31:0] mq[$];      // word addresses held in the queue, head first
  bit          m_busy;     // a request is on the bus
  bit          m_disc;     // the outstanding request is stale
  logic [31:0] m_req;      // address of the outstanding request
  logic [31:0] m_next;     // next sequential address to fetch

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic        s_valid, s_req;
  logic [31:0] s_instr, s_addr;
  logic        e_valid;
  logic [31:0] e_instr, e_head;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A50000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst_v, input logic [31:0] pc_v,
                              input logic fen_v, input logic ack_v);
    bit miss;
    bit ackd;
    if (!rst_v) begin
      mq.delete();
      m_busy = 1'b0;
      m_disc = 1'b0;
      m_req  = 32'h0;
      m_next = 32'h0;
      return;
    end
    miss = (pc_v[31:2] != e_head[31:2]);
    ackd = m_busy && ack_v;
    if (miss) begin
      mq.delete();
      m_next = {pc_v[31:2], 2'b00};
      if (m_busy && !ackd) begin
        m_disc = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_disc = 1'b0;
        m_req  = m_next;
      end
    end else begin
      if (e_valid && fen_v) void'(mq.pop_front());
      if (ackd) begin
        if (!m_disc) begin
          mq.push_back(m_req);
          m_next = m_req + 32'd4;
        end
        m_disc = 1'b0;
        m_busy = 1'b0;
      end
      if (!m_busy && mq.size() < DEPTH) begin
        m_busy = 1'b1;
        m_req  = m_next;
      end
    end
  endtask

  // One clock cycle: drive at negedge, sample and compare, then advance model
  task automatic step(input logic rst_v, input logic [31:0] pc_v,
                      input logic fen_v, input logic ack_v);
    @(negedge clk);
    reset          = rst_v;
    bus.pcF        = pc_v;
    bus.fetchen    = fen_v;
    bus.imem_ack   = ack_v;
    bus.imem_rdata = ack_v ? memf(bus.imem_addr) : $urandom;
    #1;
    s_valid = bus.instrvalidF;
    s_instr = bus.instrF;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    e_head  = (mq.size() > 0) ? mq[0] : ((m_busy && !m_disc) ? m_req : m_next);
    e_valid = (mq.size() > 0) && (pc_v[31:2] == e_head[31:2]);
    e_instr = e_valid ? memf(mq[0]) : 32'h0;
    if (chk_en) begin
      check("instrvalidF", 32'(s_valid), 32'(e_valid));
      check("instrF", s_instr, e_instr);
      check("imem_req", 32'(s_req), 32'(m_busy));
      if (m_busy) check("imem_addr", s_addr, m_req);
    end
    @(posedge clk);
    model_update(rst_v, pc_v, fen_v, ack_v);
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] addrs[$];
    logic        fen_r;
    int          nreq;
    int          r;
    logic        rst_b;
    logic        ack_b;

    reset          = 1'b0;
    bus.pcF        = 32'h0;
    bus.fetchen    = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    m_busy = 1'b0; m_disc = 1'b0; m_req = 32'h0; m_next = 32'h0;

    // 1. Reset held with ack high, then release with pcF=0
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      if (i > 0) begin
        check("t1_rst_req", 32'(s_req), 32'd0);
        check("t1_rst_valid", 32'(s_valid), 32'd0);
        check("t1_rst_instr", s_instr, 32'h0);
      end
    end
    step(1'b1, 32'h0, 1'b1, 1'b1);
    check("t1_rel_req", 32'(s_req), 32'd0);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    check("t1_first_req", 32'(s_req), 32'd1);
    check("t1_first_addr", s_addr, 32'h0);
    check("t1_first_valid", 32'(s_valid), 32'd0);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    check("t1_valid", 32'(s_valid), 32'd1);
    check("t1_instr", s_instr, 32'hA5A50000);

    // 2. Streaming at one instruction per cycle
    pc = 32'h4;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, pc, 1'b1, 1'b1);
      check("t2_valid", 32'(s_valid), 32'd1);
      check("t2_instr", s_instr, pc ^ 32'hA5A50000);
      pc = pc + 32'd4;
    end

    // 3. Fill with fetch stalled: exactly DEPTH requests
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h0, 1'b0, 1'b1);
      if (s_req) begin
        nreq++;
        addrs.push_back(s_addr);
      end
    end
    check("t3_nreq", 32'(nreq), 32'd4);
    for (int i = 0; i < addrs.size() && i < 4; i++)
      check("t3_addr", addrs[i], 32'(i) * 32'd4);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    check("t3_pop_valid", 32'(s_valid), 32'd1);
    step(1'b1, 32'h4, 1'b1, 1'b1);
    check("t3_resume_req", 32'(s_req), 32'd1);
    check("t3_resume_addr", s_addr, 32'h10);
    step(1'b1, 32'h8, 1'b1, 1'b1);
    step(1'b1, 32'hC, 1'b1, 1'b1);
    step(1'b1, 32'h10, 1'b0, 1'b1);
    step(1'b1, 32'h10, 1'b0, 1'b1);
    check("t4_full_req", 32'(s_req), 32'd0);
    check("t4_full_valid", 32'(s_valid), 32'd1);

    // 4. Redirect with queue full of 0x10..0x1C
    step(1'b1, 32'h100, 1'b1, 1'b1);
    check("t4_redir_valid", 32'(s_valid), 32'd0);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    check("t4_req", 32'(s_req), 32'd1);
    check("t4_addr", s_addr, 32'h100);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    check("t4_valid", 32'(s_valid), 32'd1);
    check("t4_instr", s_instr, 32'h100 ^ 32'hA5A50000);

    // 5. Redirect while the request to 0x8 waits three cycles for ack
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h200, 1'b0, 1'b0);
      check("t5_hold_req", 32'(s_req), 32'd1);
      check("t5_hold_addr", s_addr, 32'h8);
      check("t5_hold_valid", 32'(s_valid), 32'd0);
    end
    step(1'b1, 32'h200, 1'b0, 1'b1);
    check("t5_ack_addr", s_addr, 32'h8);
    step(1'b1, 32'h200, 1'b0, 1'b1);
    check("t5_new_req", 32'(s_req), 32'd1);
    check("t5_new_addr", s_addr, 32'h200);
    check("t5_new_valid", 32'(s_valid), 32'd0);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    check("t5_valid", 32'(s_valid), 32'd1);
    check("t5_instr", s_instr, 32'h200 ^ 32'hA5A50000);

    // 6. Reset while BUSY with three entries queued
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("t6_pre_req", 32'(s_req), 32'd1);
    check("t6_pre_addr", s_addr, 32'hC);
    check("t6_pre_valid", 32'(s_valid), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("t6_rst_req", 32'(s_req), 32'd0);
    check("t6_rst_addr", s_addr, 32'h0);
    check("t6_rst_valid", 32'(s_valid), 32'd0);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    check("t6_restart_addr", s_addr, 32'h0);
    check("t6_restart_req", 32'(s_req), 32'd1);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    check("t6_restart_valid", 32'(s_valid), 32'd1);
    check("t6_restart_instr", s_instr, 32'hA5A50000);

    // Randomized phase: stalls, slow acks, redirects, wrap, sporadic reset
    pc    = 32'h4;
    fen_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (s_valid && fen_r) pc = pc + 32'd4;
      r = int'($urandom_range(0, 99));
      if (r < 6) pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      else if (r == 6) pc = 32'hFFFF_FFF0;
      rst_b = ($urandom_range(0, 299) != 0);
      fen_r = ($urandom_range(0, 3) != 0);
      ack_b = ($urandom_range(0, 3) != 0);
      step(rst_b, pc | 32'($urandom_range(0, 3)), fen_r, ack_b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
